// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle main control FSM for the 16-bit MIPS-style datapath.
// Define MC_FLAGREG_EN to build the architectural ALU flag register; otherwise flags reads 0.
module mc_control_fsm #(
   parameter int OPW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [OPW-1:0] opcode,
   input  logic           zero,
   input  logic           carry,
   input  logic           overflow,
   input  logic           sign,
   output logic [1:0]     aluop,
   output logic           alu_src_a,
   output logic [1:0]     alu_src_b,
   output logic [1:0]     pc_source,
   output logic           pc_en,
   output logic           iord,
   output logic           mem_read,
   output logic           mem_write,
   output logic           ir_write,
   output logic           reg_write,
   output logic           reg_dst,
   output logic           mem_to_reg,
   output logic           halted,
   output logic           illegal,
   output logic [3:0]     state,
   output logic [3:0]     flags
);
   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      ADDIEX = 4'd10,
      ADDIWB = 4'd11,
      HALT   = 4'd12
   } state_t;

   typedef struct packed {
      logic [1:0] aluop;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       halted;
   } ctl_t;

   localparam logic [OPW-1:0] OP_R    = OPW'(4'h0);
   localparam logic [OPW-1:0] OP_ADDI = OPW'(4'h1);
   localparam logic [OPW-1:0] OP_LW   = OPW'(4'h2);
   localparam logic [OPW-1:0] OP_SW   = OPW'(4'h3);
   localparam logic [OPW-1:0] OP_BEQ  = OPW'(4'h4);
   localparam logic [OPW-1:0] OP_BNE  = OPW'(4'h5);
   localparam logic [OPW-1:0] OP_JMP  = OPW'(4'h6);
   localparam logic [OPW-1:0] OP_HALT = OPW'(4'hf);

   state_t st, nxt;
   ctl_t   ctl;
   logic   bad, bne, is_lw;

   // Control word of a state; registered from the next state so outputs stay pure Moore.
   function automatic ctl_t decode(state_t s);
      ctl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.mem_read  = 1'b1;
            c.ir_write  = 1'b1;
            c.alu_src_b = 2'b01;
            c.pc_write  = 1'b1;
         end
         DECODE: c.alu_src_b = 2'b11;
         MEMADR, ADDIEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         MEMRD: begin
            c.iord     = 1'b1;
            c.mem_read = 1'b1;
         end
         MEMWB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         MEMWR: begin
            c.iord      = 1'b1;
            c.mem_write = 1'b1;
         end
         EXEC: begin
            c.alu_src_a = 1'b1;
            c.aluop     = 2'b10;
         end
         ALUWB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.aluop         = 2'b01;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 2'b01;
         end
         JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = 2'b10;
         end
         ADDIWB: c.reg_write = 1'b1;
         HALT:   c.halted = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      nxt = HALT;
      bad = 1'b0;
      case (st)
         FETCH:  nxt = DECODE;
         DECODE: begin
            case (opcode)
               OP_R:           nxt = EXEC;
               OP_ADDI:        nxt = ADDIEX;
               OP_LW, OP_SW:   nxt = MEMADR;
               OP_BEQ, OP_BNE: nxt = BRANCH;
               OP_JMP:         nxt = JUMP;
               OP_HALT:        nxt = HALT;
               default:        bad = 1'b1;
            endcase
         end
         MEMADR: nxt = is_lw ? MEMRD : MEMWR;
         MEMRD:  nxt = MEMWB;
         EXEC:   nxt = ALUWB;
         ADDIEX: nxt = ADDIWB;
         HALT:   nxt = HALT;
         MEMWB, MEMWR, ALUWB, BRANCH, JUMP, ADDIWB: nxt = FETCH;
         default: bad = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= FETCH;
         ctl     <= decode(FETCH);
         illegal <= 1'b0;
         bne     <= 1'b0;
         is_lw   <= 1'b0;
`ifdef MC_FLAGREG_EN
         flags   <= 4'b0000;
`endif
      end else begin
         st  <= nxt;
         ctl <= decode(nxt);
         if (bad) illegal <= 1'b1;
         if (st == DECODE) begin
            bne   <= opcode == OP_BNE;
            is_lw <= opcode == OP_LW;
         end
`ifdef MC_FLAGREG_EN
         if (st == EXEC || st == ADDIEX) flags <= {zero, carry, overflow, sign};
`endif
      end
   end

`ifndef MC_FLAGREG_EN
   logic unused_flags;
   assign unused_flags = ^{carry, overflow, sign};
   assign flags = 4'b0000;
`endif

   assign state      = st;
   assign aluop      = ctl.aluop;
   assign alu_src_a  = ctl.alu_src_a;
   assign alu_src_b  = ctl.alu_src_b;
   assign pc_source  = ctl.pc_source;
   assign iord       = ctl.iord;
   assign mem_read   = ctl.mem_read;
   assign mem_write  = ctl.mem_write;
   assign ir_write   = ctl.ir_write;
   assign reg_write  = ctl.reg_write;
   assign reg_dst    = ctl.reg_dst;
   assign mem_to_reg = ctl.mem_to_reg;
   assign halted     = ctl.halted;
   assign pc_en      = ctl.pc_write | (ctl.pc_write_cond & (zero ^ bne));
endmodule
